// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader and its RX core.
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE, LEN, DATA, WRITE, CSUM, DONE, ERROR
    } boot_state_t;

    typedef enum logic [1:0] {
        RX_HUNT, RX_START, RX_BITS, RX_STOP
    } rx_state_t;

    localparam logic [7:0]  BOOT_MAGIC        = 8'hA5;
    localparam logic [31:0] DEFAULT_LOAD_BASE = 32'h0001_0000;
    localparam int unsigned LEN_BYTES         = 4;

    // Oversample divisor: round(clk / (16 * baud)), never below 1.
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        int unsigned d;
        d = (clk_hz + 8 * baud) / (16 * baud);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_boot_loader_if.sv
// RAM write port between the boot loader (master) and the memory (slave).
interface uart_boot_loader_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master(output mem_valid, output mem_addr, output mem_wdata, input mem_ready);
    modport slave (input mem_valid, input mem_addr, input mem_wdata, output mem_ready);
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer, 16x oversampling, mid-bit sampling.
module uart_rx_core
    import boot_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_ferr
);

    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [3:0]  MID   = 4'd7;

    rx_state_t        state;
    logic [2:0]       sync;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       samp;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             tick_c;

    assign tick_c = (div_cnt == DIV_W'(DIV - 1));

    // sync[1] is the synchronized line, sync[2] its previous value for edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync     <= 3'b111;
            state    <= RX_HUNT;
            div_cnt  <= '0;
            samp     <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            rx_ferr  <= 1'b0;
        end else begin
            sync     <= {sync[1:0], rxd};
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            if (state == RX_HUNT) begin
                if (sync[2] && !sync[1]) begin
                    state   <= RX_START;
                    div_cnt <= '0;
                    samp    <= '0;
                end
            end else if (!tick_c) begin
                div_cnt <= div_cnt + DIV_W'(1);
            end else begin
                div_cnt <= '0;
                samp    <= samp + 4'd1;
                if (samp == MID) begin
                    case (state)
                        RX_START: if (sync[1]) state <= RX_HUNT;
                        RX_BITS:  shreg <= {sync[1], shreg[7:1]};
                        RX_STOP: begin
                            state <= RX_HUNT;
                            if (sync[1]) begin
                                rx_valid <= 1'b1;
                                rx_data  <= shreg;
                            end else begin
                                rx_ferr <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                if (samp == 4'd15) begin
                    case (state)
                        RX_START: begin
                            state   <= RX_BITS;
                            bit_idx <= '0;
                        end
                        RX_BITS: begin
                            if (bit_idx == 3'd7) state <= RX_STOP;
                            else                 bit_idx <= bit_idx + 3'd1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Loads a UART-delivered image into RAM and releases the CPU once the checksum matches.
// Optional inter-byte timeout is built when BOOT_TIMEOUT_EN is defined.
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned BAUD        = 115200,
    parameter logic [31:0] LOAD_BASE   = DEFAULT_LOAD_BASE,
    parameter int unsigned MAX_WORDS   = 16384
`ifdef BOOT_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 5000000
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                uart_rxd,
    uart_boot_loader_if.master  mem,
    output logic                cpu_hold,
    output logic                boot_done,
    output logic                boot_error
);

    localparam int unsigned DIV = calc_div(CLK_FREQ_HZ, BAUD);

    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ferr;

    boot_state_t state;
    logic [1:0]  byte_cnt;
    logic [31:0] len;
    logic [31:0] word_cnt;
    logic [31:0] word;
    logic [7:0]  sum;
    logic        hold_valid;
    logic [7:0]  hold_data;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    logic        byte_valid_c;
    logic [7:0]  byte_data_c;
    logic [31:0] new_len_c;
    logic [31:0] new_word_c;
    logic        active_c;
    logic        timeout_c;
    logic        fail_c;

    uart_rx_core #(.DIV(DIV)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rxd      (uart_rxd),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ferr  (rx_ferr)
    );

    assign mem.mem_valid = mem_valid;
    assign mem.mem_addr  = mem_addr;
    assign mem.mem_wdata = mem_wdata;

`ifdef BOOT_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst || !active_c || rx_valid) tmo_cnt <= '0;
        else                              tmo_cnt <= tmo_cnt + 32'd1;
    end

    assign timeout_c = active_c && !rx_valid && (tmo_cnt >= 32'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_c = 1'b0;
`endif

    // A parked byte always takes precedence over a fresh one.
    always_comb begin
        byte_valid_c = hold_valid || rx_valid;
        byte_data_c  = hold_valid ? hold_data : rx_data;
        new_len_c    = {byte_data_c, len[31:8]};
        new_word_c   = {byte_data_c, word[31:8]};
        active_c     = (state == LEN) || (state == DATA) || (state == WRITE) || (state == CSUM);
        fail_c       = (rx_ferr && active_c)
                     || ((state == WRITE) && rx_valid && hold_valid)
                     || timeout_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            len        <= '0;
            word_cnt   <= '0;
            word       <= '0;
            sum        <= '0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            mem_valid  <= 1'b0;
            mem_addr   <= LOAD_BASE;
            mem_wdata  <= '0;
            boot_done  <= 1'b0;
            boot_error <= 1'b0;
            cpu_hold   <= 1'b1;
        end else begin
            if (state == WRITE) begin
                if (rx_valid && !hold_valid) begin
                    hold_valid <= 1'b1;
                    hold_data  <= rx_data;
                end
            end else if (hold_valid) begin
                if (rx_valid) hold_data  <= rx_data;
                else          hold_valid <= 1'b0;
            end

            if (fail_c) begin
                state      <= ERROR;
                boot_error <= 1'b1;
                mem_valid  <= 1'b0;
                hold_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE, ERROR: begin
                        if (byte_valid_c && byte_data_c == BOOT_MAGIC) begin
                            state      <= LEN;
                            boot_error <= 1'b0;
                            byte_cnt   <= '0;
                            sum        <= '0;
                            word_cnt   <= '0;
                            mem_addr   <= LOAD_BASE;
                        end
                    end
                    LEN: begin
                        if (byte_valid_c) begin
                            len      <= new_len_c;
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'(LEN_BYTES - 1)) begin
                                byte_cnt <= '0;
                                if (new_len_c == 32'd0) begin
                                    state <= CSUM;
                                end else if (new_len_c > 32'(MAX_WORDS)) begin
                                    state      <= ERROR;
                                    boot_error <= 1'b1;
                                    hold_valid <= 1'b0;
                                end else begin
                                    state <= DATA;
                                end
                            end
                        end
                    end
                    DATA: begin
                        if (byte_valid_c) begin
                            word     <= new_word_c;
                            sum      <= sum + byte_data_c;
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3) begin
                                byte_cnt  <= '0;
                                mem_wdata <= new_word_c;
                                mem_valid <= 1'b1;
                                state     <= WRITE;
                            end
                        end
                    end
                    WRITE: begin
                        if (mem_valid && mem.mem_ready) begin
                            mem_valid <= 1'b0;
                            mem_addr  <= mem_addr + 32'd4;
                            word_cnt  <= word_cnt + 32'd1;
                            state     <= (word_cnt + 32'd1 == len) ? CSUM : DATA;
                        end
                    end
                    CSUM: begin
                        if (byte_valid_c) begin
                            hold_valid <= 1'b0;
                            if (byte_data_c == sum) begin
                                state     <= DONE;
                                boot_done <= 1'b1;
                                cpu_hold  <= 1'b0;
                            end else begin
                                state      <= ERROR;
                                boot_error <= 1'b1;
                            end
                        end
                    end
                    DONE:    hold_valid <= 1'b0;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
